// File: rtl/dmg_timer_div_if.sv
// CPU-side register bus of the DMG timer: write strobe, register select, data and interrupt.
interface dmg_timer_div_if;
    logic       wr_en;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq_timer;

    modport master (output wr_en, addr, wdata, input rdata, irq_timer);
    modport slave  (input wr_en, addr, wdata, output rdata, irq_timer);
endinterface

// File: rtl/dmg_timer_div.sv
// DMG DIV/TIMA/TMA/TAC timer with delayed TMA reload and timer interrupt.
// Define DMG_TIMER_DIV_GLITCH_EN to make a DIV write act as a falling edge of the selected divider bit.
module dmg_timer_div #(
    parameter int          T_OUT    = 0,
    parameter logic [15:0] INIT_DIV = 16'h0000
) (
    input  logic           dffra_clk,
    input  logic           nreset,
    dmg_timer_div_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        OVF,
        RELOAD
    } state_t;

    state_t      state, state_next;
    logic [15:0] div, div_next;
    logic [7:0]  tima, tima_next;
    logic [7:0]  tma, tma_next;
    logic [2:0]  tac, tac_next;
    logic [1:0]  cnt, cnt_next;
    logic        edge_prev, edge_prev_next;
    logic        irq, irq_next;
    logic        sel_bit, tick, inc;
    logic        wr_div, wr_tima, wr_tma, wr_tac;
    logic [7:0]  rdata_mux;

    // Output delays exist only in the cell-level model; the synthesized outputs are zero-delay.
    logic [31:0] unused_t_out;
    assign unused_t_out = T_OUT;

    assign wr_div  = bus.wr_en && (bus.addr == 2'd0);
    assign wr_tima = bus.wr_en && (bus.addr == 2'd1);
    assign wr_tma  = bus.wr_en && (bus.addr == 2'd2);
    assign wr_tac  = bus.wr_en && (bus.addr == 2'd3);

    always_comb begin
        sel_bit = div[9];
        case (tac[1:0])
            2'b00: sel_bit = div[9];
            2'b01: sel_bit = div[3];
            2'b10: sel_bit = div[5];
            2'b11: sel_bit = div[7];
            default: sel_bit = div[9];
        endcase
    end

    assign tick = tac[2] & sel_bit;

`ifdef DMG_TIMER_DIV_GLITCH_EN
    assign inc = (edge_prev & ~tick) | (wr_div & tick);
`else
    assign inc = edge_prev & ~tick;
`endif

    always_comb begin
        div_next   = wr_div ? 16'h0000 : div + 16'd1;
        tma_next   = wr_tma ? bus.wdata : tma;
        tac_next   = wr_tac ? bus.wdata[2:0] : tac;
        // A DIV write never leaves a stale high tick behind to fall on the following cycle.
        edge_prev_next = wr_div ? 1'b0 : tick;
        state_next = state;
        tima_next  = tima;
        cnt_next   = cnt;
        irq_next   = 1'b0;

        case (state)
            IDLE: begin
                if (wr_tima) begin
                    tima_next = bus.wdata;
                end else if (inc) begin
                    if (tima == 8'hFF) begin
                        tima_next  = 8'h00;
                        cnt_next   = 2'd3;
                        state_next = OVF;
                    end else begin
                        tima_next = tima + 8'd1;
                    end
                end
            end
            OVF: begin
                if (wr_tima) begin
                    tima_next  = bus.wdata;
                    state_next = IDLE;
                end else if (cnt == 2'd0) begin
                    tima_next  = tma_next;
                    irq_next   = 1'b1;
                    state_next = RELOAD;
                end else begin
                    cnt_next = cnt - 2'd1;
                    if (inc) begin
                        tima_next = tima + 8'd1;
                    end
                end
            end
            RELOAD: begin
                tima_next  = tma_next;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge dffra_clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            div       <= INIT_DIV;
            tima      <= 8'h00;
            tma       <= 8'h00;
            tac       <= 3'b000;
            cnt       <= 2'd0;
            edge_prev <= 1'b0;
            irq       <= 1'b0;
        end else begin
            state     <= state_next;
            div       <= div_next;
            tima      <= tima_next;
            tma       <= tma_next;
            tac       <= tac_next;
            cnt       <= cnt_next;
            edge_prev <= edge_prev_next;
            irq       <= irq_next;
        end
    end

    always_comb begin
        rdata_mux = div[15:8];
        case (bus.addr)
            2'd0: rdata_mux = div[15:8];
            2'd1: rdata_mux = tima;
            2'd2: rdata_mux = tma;
            2'd3: rdata_mux = {5'b11111, tac};
            default: rdata_mux = div[15:8];
        endcase
    end

    assign bus.rdata     = rdata_mux;
    assign bus.irq_timer = irq;
endmodule

// File: tb/tb_dmg_timer_div.sv
// Scoreboard bench for dmg_timer_div: expected values are queued with the stimulus and popped at each sample.
module tb_dmg_timer_div;
    logic clk = 1'b0;
    logic nreset = 1'b1;

    dmg_timer_div_if bus();

    dmg_timer_div dut (
        .dffra_clk(clk),
        .nreset(nreset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] value;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   tests_run = 0;
    int   tests_failed = 0;

    function automatic exp_t mk(input string name, input logic [7:0] value);
        exp_t x;
        x.name  = name;
        x.value = value;
        return x;
    endfunction

    // All sampling happens just after a falling clock edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        cycles(1);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_tima_zero();
        bus.addr = 2'd1;
        #1;
        for (int n = 0; n < 40 && bus.rdata !== 8'h00; n++) cycles(1);
    endtask

    task automatic arm_overflow(input logic [7:0] tma_val);
        bus_write(2'd3, 8'h05);
        bus_write(2'd2, tma_val);
        bus_write(2'd1, 8'hFF);
    endtask

    task automatic test_reset();
        bus.wr_en = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = 8'h00;
        #3 nreset = 1'b0;
        cycles(3);
        sb_q.push_back(mk("reset DIV", 8'h00));
        sb_q.push_back(mk("reset TIMA", 8'h00));
        sb_q.push_back(mk("reset TMA", 8'h00));
        sb_q.push_back(mk("reset TAC", 8'hF8));
        sb_q.push_back(mk("reset irq", 8'h00));
        sb_q.push_back(mk("DIV after 255 clocks", 8'h00));
        sb_q.push_back(mk("DIV after 256 clocks", 8'h01));
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a);
            #1;
            e = sb_q.pop_front(); tests_run++;
            if (bus.rdata !== e.value) begin
                tests_failed++;
                $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
            end
        end
        e = sb_q.pop_front(); tests_run++;
        if (bus.irq_timer !== e.value[0]) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %0b, expected %0b", e.name, bus.irq_timer, e.value[0]);
        end
        bus.addr = 2'd0;
        @(negedge clk);
        nreset = 1'b1;
        repeat (255) @(posedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (bus.rdata !== e.value) begin
                tests_failed++;
                $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
            end
            cycles(1);
        end
    endtask

    task automatic test_registers();
        sb_q.push_back(mk("DIV write clears", 8'h00));
        sb_q.push_back(mk("TMA readback", 8'h3C));
        sb_q.push_back(mk("TAC readback FF", 8'hFF));
        sb_q.push_back(mk("TAC readback 02", 8'hFA));
        bus_write(2'd0, 8'hA5);
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
        bus_write(2'd2, 8'h3C);
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
        bus_write(2'd3, 8'hFF);
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
        bus_write(2'd3, 8'h02);
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
    endtask

    task automatic test_count();
        bus_write(2'd3, 8'h05);
        bus_write(2'd2, 8'h00);
        bus_write(2'd1, 8'h00);
        sb_q.push_back(mk("TIMA after 160 clocks", 8'h0A));
        cycles(160);
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
    endtask

    task automatic test_overflow();
        arm_overflow(8'hAB);
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(mk($sformatf("OVF TIMA clock %0d", i), 8'h00));
            sb_q.push_back(mk($sformatf("OVF irq clock %0d", i), 8'h00));
        end
        sb_q.push_back(mk("reload TIMA", 8'hAB));
        sb_q.push_back(mk("reload irq", 8'h01));
        sb_q.push_back(mk("post-reload TIMA", 8'hAB));
        sb_q.push_back(mk("post-reload irq", 8'h00));
        wait_tima_zero();
        for (int i = 0; i < 6; i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (bus.rdata !== e.value) begin
                tests_failed++;
                $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
            end
            e = sb_q.pop_front(); tests_run++;
            if (bus.irq_timer !== e.value[0]) begin
                tests_failed++;
                $display("[TB] FAIL %s: read %0b, expected %0b", e.name, bus.irq_timer, e.value[0]);
            end
            if (i < 5) cycles(1);
        end
    endtask

    task automatic test_ovf_write();
        arm_overflow(8'hAB);
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(mk($sformatf("OVF write TIMA clock %0d", i), 8'h42));
            sb_q.push_back(mk($sformatf("OVF write irq clock %0d", i), 8'h00));
        end
        wait_tima_zero();
        bus_write(2'd1, 8'h42);
        for (int i = 0; i < 6; i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (bus.rdata !== e.value) begin
                tests_failed++;
                $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
            end
            e = sb_q.pop_front(); tests_run++;
            if (bus.irq_timer !== e.value[0]) begin
                tests_failed++;
                $display("[TB] FAIL %s: read %0b, expected %0b", e.name, bus.irq_timer, e.value[0]);
            end
            cycles(1);
        end
    endtask

    task automatic test_reload_write();
        arm_overflow(8'hAB);
        sb_q.push_back(mk("RELOAD irq (TMA write)", 8'h01));
        sb_q.push_back(mk("TIMA after TMA write in RELOAD", 8'h55));
        sb_q.push_back(mk("irq after TMA write in RELOAD", 8'h00));
        wait_tima_zero();
        cycles(4);
        e = sb_q.pop_front(); tests_run++;
        if (bus.irq_timer !== e.value[0]) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %0b, expected %0b", e.name, bus.irq_timer, e.value[0]);
        end
        bus_write(2'd2, 8'h55);
        bus.addr = 2'd1;
        #1;
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
        e = sb_q.pop_front(); tests_run++;
        if (bus.irq_timer !== e.value[0]) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %0b, expected %0b", e.name, bus.irq_timer, e.value[0]);
        end

        arm_overflow(8'h55);
        sb_q.push_back(mk("RELOAD irq (TIMA write)", 8'h01));
        sb_q.push_back(mk("TIMA write in RELOAD ignored", 8'h55));
        wait_tima_zero();
        cycles(4);
        e = sb_q.pop_front(); tests_run++;
        if (bus.irq_timer !== e.value[0]) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %0b, expected %0b", e.name, bus.irq_timer, e.value[0]);
        end
        bus_write(2'd1, 8'h99);
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
    endtask

    task automatic test_glitch();
        bus_write(2'd3, 8'h05);
        bus_write(2'd0, 8'h00);
        bus_write(2'd1, 8'h10);
        sb_q.push_back(mk("TIMA before DIV write", 8'h10));
`ifdef DMG_TIMER_DIV_GLITCH_EN
        sb_q.push_back(mk("TIMA after glitch DIV write", 8'h11));
`else
        sb_q.push_back(mk("TIMA after DIV write", 8'h10));
`endif
        sb_q.push_back(mk("DIV after DIV write", 8'h00));
        // div now counts up from 1; after nine more clocks div[3] is high.
        cycles(9);
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
        bus_write(2'd0, 8'h7E);
        cycles(2);
        bus.addr = 2'd1;
        #1;
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
        bus.addr = 2'd0;
        #1;
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
    endtask

    task automatic test_reset_abort();
        logic irq_seen;
        arm_overflow(8'h77);
        sb_q.push_back(mk("irq in mid-OVF reset", 8'h00));
        sb_q.push_back(mk("TIMA in mid-OVF reset", 8'h00));
        sb_q.push_back(mk("TAC in mid-OVF reset", 8'hF8));
        sb_q.push_back(mk("irq after aborted reload", 8'h00));
        sb_q.push_back(mk("TIMA after aborted reload", 8'h00));
        wait_tima_zero();
        cycles(2);
        nreset = 1'b0;
        #1;
        e = sb_q.pop_front(); tests_run++;
        if (bus.irq_timer !== e.value[0]) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %0b, expected %0b", e.name, bus.irq_timer, e.value[0]);
        end
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
        bus.addr = 2'd3;
        #1;
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
        nreset = 1'b1;
        bus.addr = 2'd1;
        irq_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            irq_seen = irq_seen | bus.irq_timer;
        end
        e = sb_q.pop_front(); tests_run++;
        if (irq_seen !== e.value[0]) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %0b, expected %0b", e.name, irq_seen, e.value[0]);
        end
        e = sb_q.pop_front(); tests_run++;
        if (bus.rdata !== e.value) begin
            tests_failed++;
            $display("[TB] FAIL %s: read %02h, expected %02h", e.name, bus.rdata, e.value);
        end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_count();
        test_overflow();
        test_ovf_write();
        test_reload_write();
        test_glitch();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
